// File: rtl/ex_muldiv_unit.sv
// Multi-cycle multiply/divide unit for the EX stage: one-cycle multiply, restoring
// divide on magnitudes resolving DIV_BPC quotient bits per cycle, flush cancel.
module ex_muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int DIV_BPC = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic            cancel,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy
);

  localparam int ITERS = XLEN / DIV_BPC;
  localparam int CNT_W = $clog2(ITERS);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        op_reg;
  logic [XLEN-1:0]   src1_reg, src2_reg;
  logic [XLEN-1:0]   rem_reg, quo_reg, dvs_reg;
  logic              neg_q_reg, neg_r_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [XLEN-1:0]   result_reg;

  logic              accept, div_zero, signed_div;
  logic              src1_neg, src2_neg;
  logic [XLEN-1:0]   src1_abs, src2_abs;

  assign accept     = (state_reg == S_IDLE) & req_valid & ~cancel;
  assign div_zero   = (req_src2 == '0);
  assign signed_div = req_op[2] & ~req_op[1];
  assign src1_neg   = signed_div & req_src1[XLEN-1];
  assign src2_neg   = signed_div & req_src2[XLEN-1];
  assign src1_abs   = src1_neg ? -req_src1 : req_src1;
  assign src2_abs   = src2_neg ? -req_src2 : req_src2;

  // Full-width product; zero extension for unsigned high, sign extension otherwise
  // (the low half is identical either way).
  logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;
  logic [XLEN-1:0]   mul_sel;

  assign mul_a    = op_reg[1] ? {{XLEN{1'b0}}, src1_reg} : {{XLEN{src1_reg[XLEN-1]}}, src1_reg};
  assign mul_b    = op_reg[1] ? {{XLEN{1'b0}}, src2_reg} : {{XLEN{src2_reg[XLEN-1]}}, src2_reg};
  assign mul_prod = mul_a * mul_b;

  always_comb begin
    mul_sel = '0;
    case (op_reg)
      2'b00:   mul_sel = mul_prod[XLEN-1:0];
      2'b01:   mul_sel = mul_prod[2*XLEN-1:XLEN];
      2'b10:   mul_sel = mul_prod[2*XLEN-1:XLEN];
      default: mul_sel = '0;
    endcase
  end

  // Chain of DIV_BPC restoring steps; the dividend is shifted out of quo_reg
  // while quotient bits shift in from the bottom.
  logic [XLEN-1:0] rem_chain [DIV_BPC+1];
  logic [XLEN-1:0] quo_chain [DIV_BPC+1];

  assign rem_chain[0] = rem_reg;
  assign quo_chain[0] = quo_reg;

  generate
    for (genvar gi = 0; gi < DIV_BPC; gi++) begin : g_div_step
      logic [XLEN:0]   shifted;
      logic [XLEN-1:0] diff;
      logic            ge;
      assign shifted = {rem_chain[gi], quo_chain[gi][XLEN-1]};
      assign ge      = (shifted >= {1'b0, dvs_reg});
      // Only used when ge, in which case the true difference fits XLEN bits.
      assign diff    = shifted[XLEN-1:0] - dvs_reg;
      assign rem_chain[gi+1] = ge ? diff : shifted[XLEN-1:0];
      assign quo_chain[gi+1] = {quo_chain[gi][XLEN-2:0], ge};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (accept) begin
          if (!req_op[2])   state_next = S_MUL;
          else if (div_zero) state_next = S_DONE;
          else              state_next = S_DIV;
        end
      end
      S_MUL: state_next = S_DONE;
      S_DIV: if (cnt_reg == CNT_W'(ITERS - 1)) state_next = S_FIX;
      S_FIX: state_next = S_DONE;
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (cancel) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_reg     <= '0;
      src1_reg   <= '0;
      src2_reg   <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      dvs_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      cnt_reg    <= '0;
      result_reg <= '0;
    end else if (cancel) begin
      cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            op_reg    <= req_op[1:0];
            src1_reg  <= req_src1;
            src2_reg  <= req_src2;
            rem_reg   <= '0;
            quo_reg   <= src1_abs;
            dvs_reg   <= src2_abs;
            neg_q_reg <= src1_neg ^ src2_neg;
            neg_r_reg <= src1_neg;
            cnt_reg   <= '0;
            if (req_op[2] && div_zero) result_reg <= req_op[0] ? req_src1 : '1;
          end
        end
        S_MUL: result_reg <= mul_sel;
        S_DIV: begin
          rem_reg <= rem_chain[DIV_BPC];
          quo_reg <= quo_chain[DIV_BPC];
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        S_FIX: begin
          if (op_reg[0]) result_reg <= neg_r_reg ? -rem_reg : rem_reg;
          else           result_reg <= neg_q_reg ? -quo_reg : quo_reg;
        end
        default: ;
      endcase
    end
  end

  assign resp_result = result_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: three instances (32/1, 32/2, 16/1) checked every cycle
// against an arithmetic model of result and handshake timing.
module tb_ex_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [2:0]  req_valid, req_ready, cancel, resp_valid, resp_ready, busy;
  logic [2:0]  req_op [3];
  logic [31:0] src1 [3];
  logic [31:0] src2 [3];
  logic [31:0] res0, res1;
  logic [15:0] res2;

  ex_muldiv_unit #(.XLEN(32), .DIV_BPC(1)) u_dut0 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op(req_op[0]), .req_src1(src1[0]), .req_src2(src2[0]), .cancel(cancel[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_result(res0), .busy(busy[0]));

  ex_muldiv_unit #(.XLEN(32), .DIV_BPC(2)) u_dut1 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op(req_op[1]), .req_src1(src1[1]), .req_src2(src2[1]), .cancel(cancel[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_result(res1), .busy(busy[1]));

  ex_muldiv_unit #(.XLEN(16), .DIV_BPC(1)) u_dut2 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_op(req_op[2]), .req_src1(src1[2][15:0]), .req_src2(src2[2][15:0]), .cancel(cancel[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_result(res2), .busy(busy[2]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          pend [3];
  int          acc_cyc [3];
  int          exp_cyc [3];
  logic [31:0] exp_res [3];
  bit          post_rst [3];
  bit          chk_on = 1'b0;

  function automatic int cfg_xl(int i);
    return (i == 2) ? 16 : 32;
  endfunction

  function automatic int cfg_bpc(int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic logic [31:0] get_res(int i);
    if (i == 0) return res0;
    if (i == 1) return res1;
    return {16'h0, res2};
  endfunction

  // Result from plain integer arithmetic on the operands.
  function automatic longint unsigned model(int op, longint unsigned a, longint unsigned b, int xl);
    longint unsigned m, r;
    longint sa, sb, p;
    m  = (64'd1 << xl) - 64'd1;
    sa = longint'(a);
    sb = longint'(b);
    if (a[xl-1]) sa = sa - (longint'(1) << xl);
    if (b[xl-1]) sb = sb - (longint'(1) << xl);
    r = 0;
    case (op)
      0: r = a * b;
      1: begin p = sa * sb; p = p >>> xl; r = p; end
      2: r = (a * b) >> xl;
      3: r = 0;
      4: if (b == 0) r = m; else begin p = sa / sb; r = p; end
      5: if (b == 0) r = a; else begin p = sa % sb; r = p; end
      6: if (b == 0) r = m; else r = a / b;
      default: if (b == 0) r = a; else r = a % b;
    endcase
    return r & m;
  endfunction

  function automatic int lat(int i, logic [2:0] op, logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 0) return 1;
    return cfg_xl(i) / cfg_bpc(i) + 2;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model of the outstanding transaction.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        bit ev, eb;
        ev = pend[i] && (cyc >= exp_cyc[i]);
        eb = pend[i] && (cyc > acc_cyc[i]);
        chk($sformatf("resp_valid%0d", i), resp_valid[i], ev);
        chk($sformatf("busy%0d", i), busy[i], eb);
        chk($sformatf("req_ready%0d", i), req_ready[i], !eb);
        if (ev && resp_valid[i]) chk($sformatf("resp_result%0d", i), get_res(i), exp_res[i]);
        if (post_rst[i]) chk($sformatf("reset_result%0d", i), get_res(i), 0);
        if (cancel[i] || !resetn) pend[i] = 1'b0;
        else if (ev && resp_ready[i]) pend[i] = 1'b0;
        post_rst[i] = !resetn;
      end
    end
  end

  task automatic start(input int i, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] lit);
    @(posedge clk); #1;
    chk("req_ready_before_issue", req_ready[i], 1);
    req_valid[i] = 1'b1;
    req_op[i]    = op;
    src1[i]      = a;
    src2[i]      = b;
    exp_res[i]   = 32'(model(int'(op), a, b, cfg_xl(i)));
    chk("model_vs_literal", exp_res[i], lit);
    acc_cyc[i]   = cyc;
    exp_cyc[i]   = cyc + lat(i, op, b);
    pend[i]      = 1'b1;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic finish_op(input int i, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] lit, input int hold);
    int n = 0;
    while (!resp_valid[i] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("resp_valid_within_budget", resp_valid[i], 1);
    chk("result_vs_literal", get_res(i), lit);
    $display("txn inst=%0d op=%0d src1=%h src2=%h result=%h expected=%h", i, op, a, b, get_res(i), lit);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
    end
    resp_ready[i] = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_op(input int i, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] lit, input int hold);
    if (hold > 0) resp_ready[i] = 1'b0;
    start(i, op, a, b, lit);
    finish_op(i, op, a, b, lit, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b0;
    req_valid  = '0;
    cancel     = '0;
    resp_ready = '1;
    for (int i = 0; i < 3; i++) begin
      req_op[i] = '0; src1[i] = '0; src2[i] = '0;
      pend[i] = 1'b0; acc_cyc[i] = 0; exp_cyc[i] = 0; exp_res[i] = '0;
      post_rst[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    chk_on = 1'b1;

    // Multiply
    do_op(0, 3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 0);
    do_op(0, 3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 0);
    do_op(0, 3'b010, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 0);
    do_op(0, 3'b011, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 0);
    // Signed divide, 1 and 2 bits per cycle
    do_op(0, 3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 0);
    do_op(0, 3'b101, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 0);
    do_op(1, 3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 0);
    do_op(1, 3'b101, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 0);
    do_op(1, 3'b111, 32'd1000, 32'd7, 32'd6, 0);
    // Special cases
    do_op(0, 3'b110, 32'h00000055, 32'h00000000, 32'hFFFFFFFF, 0);
    do_op(0, 3'b111, 32'h00001234, 32'h00000000, 32'h00001234, 0);
    do_op(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    do_op(0, 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);
    // Backpressure: result and req_ready held for 5 cycles
    do_op(0, 3'b000, 32'h00000007, 32'h00000006, 32'h0000002A, 5);
    chk("req_ready_after_consume", req_ready[0], 1);

    // Cancel at divide iteration 10
    start(0, 3'b110, 32'd1000, 32'd3, 32'd333);
    repeat (10) begin @(posedge clk); #1; end
    cancel[0] = 1'b1;
    @(posedge clk); #1;
    cancel[0] = 1'b0;
    chk("req_ready_after_cancel", req_ready[0], 1);
    $display("txn inst=0 op=6 src1=%h src2=%h cancelled at iteration 10", 32'd1000, 32'd3);
    do_op(0, 3'b110, 32'd100, 32'd7, 32'd14, 0);

    // Cancel together with a request in IDLE: not accepted
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_op[0] = 3'b000; src1[0] = 32'd3; src2[0] = 32'd4; cancel[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0; cancel[0] = 1'b0;
    chk("busy_after_cancelled_req", busy[0], 0);
    $display("txn inst=0 op=0 request with cancel, not accepted");

    // Cancel in DONE with resp_ready: consumed, not replayed
    start(0, 3'b000, 32'd3, 32'd5, 32'd15);
    begin
      int n = 0;
      while (!resp_valid[0] && n < 20) begin @(posedge clk); #1; n++; end
    end
    chk("resp_valid_before_done_cancel", resp_valid[0], 1);
    cancel[0] = 1'b1;
    @(posedge clk); #1;
    cancel[0] = 1'b0;
    chk("no_replay_after_done_cancel", resp_valid[0], 0);
    $display("txn inst=0 op=0 cancelled in DONE");

    // Reset during a divide
    start(0, 3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
    repeat (5) begin @(posedge clk); #1; end
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    chk("reset_req_ready", req_ready[0], 1);
    chk("reset_resp_valid", resp_valid[0], 0);
    chk("reset_busy", busy[0], 0);
    chk("reset_resp_result", res0, 0);
    $display("txn inst=0 op=4 reset during divide");

    // 16-bit width
    do_op(2, 3'b110, 32'h0000FFFF, 32'h00000003, 32'h00005555, 0);
    do_op(2, 3'b001, 32'h0000FFFF, 32'h00000002, 32'h0000FFFF, 0);
    do_op(2, 3'b100, 32'h00008000, 32'h0000FFFF, 32'h00008000, 0);
    do_op(2, 3'b111, 32'h00001234, 32'h00000000, 32'h00001234, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
